// File: rtl/pulse_pkg.sv
// Shared definitions for the step-pulse generator/receiver pair: axis-state
// encoding and default axis count / position width.
package pulse_pkg;

  localparam int NAX_DEF   = 6;
  localparam int POS_W_DEF = 16;

  typedef enum logic [1:0] {
    UNHOMED = 2'd0,
    IDLE    = 2'd1,
    MOVING  = 2'd2
  } axis_state_t;

endpackage

// File: rtl/pulse_axis.sv
// One receiver axis: input synchronisers, step/stop edge detection, homing
// state machine, idle timer, saturating position and sticky fault.
// Optional glitch filter on PU selected by PULSE_MON_FILTER_EN.
module pulse_axis
  import pulse_pkg::*;
#(
  parameter int POS_W       = POS_W_DEF,
  parameter int IDLE_CYCLES = 200,
  parameter int FILT_LEN    = 3
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             pu,
  input  logic             dr,
  input  logic             mf,
  input  logic             stop,
  input  logic             clr_fault,
  output logic [POS_W-1:0] pos,
  output logic             homed,
  output logic             moving,
  output logic             fault
);

  localparam int CNT_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

  if (FILT_LEN < 1) begin : g_bad_filt
    $error("FILT_LEN must be at least 1");
  end

  logic [1:0]  pu_s, dr_s, mf_s, stop_s;
  logic        stop_d;
  logic [1:0]  fill;
  logic        armed;
  logic        step_det;
  logic        step_q, dir_q, mf_q, stop_q;
  logic [CNT_W-1:0] idle_cnt;
  axis_state_t state, state_nxt;

  // A PU line already high when reset releases must go low before it can step;
  // armed only sets once the synchroniser holds a real, low sample.
  // NOTE: every register, synchronisers included, is cleared by the
  // synchronous reset so behaviour after release is fully deterministic.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      pu_s   <= '0;
      dr_s   <= '0;
      mf_s   <= '0;
      stop_s <= '0;
      stop_d <= 1'b0;
      fill   <= '0;
      armed  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let each shift stage read the old value.
      pu_s   <= {pu_s[0], pu};
      dr_s   <= {dr_s[0], dr};
      mf_s   <= {mf_s[0], mf};
      stop_s <= {stop_s[0], stop};
      stop_d <= stop_s[1];
      fill   <= {fill[0], 1'b1};
      armed  <= armed | (fill[1] & ~pu_s[1]);
    end
  end

`ifdef PULSE_MON_FILTER_EN
  localparam int FC_W = $clog2(FILT_LEN + 1);
  logic [FC_W-1:0] hi_cnt;

  always_ff @(posedge sysclk) begin
    if (!rst_n)                         hi_cnt <= '0;
    else if (!pu_s[1])                  hi_cnt <= '0;
    else if (hi_cnt != FC_W'(FILT_LEN)) hi_cnt <= hi_cnt + FC_W'(1);
  end

  assign step_det = pu_s[1] & armed & (hi_cnt == FC_W'(FILT_LEN - 1));
`else
  logic pu_d;

  always_ff @(posedge sysclk) begin
    if (!rst_n) pu_d <= 1'b0;
    else        pu_d <= pu_s[1];
  end

  assign step_det = pu_s[1] & ~pu_d & armed;
`endif

  // Events are registered together with the direction and motor-free level
  // seen in the same cycle as the edge.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      step_q <= 1'b0;
      dir_q  <= 1'b0;
      mf_q   <= 1'b0;
      stop_q <= 1'b0;
    end else begin
      step_q <= step_det;
      dir_q  <= dr_s[1];
      mf_q   <= mf_s[1];
      stop_q <= stop_s[1] & ~stop_d;
    end
  end

  logic step_ok, blocked, fault_set;

  assign step_ok   = step_q & ~mf_q & ~stop_q;
  assign blocked   = step_ok & (dir_q ? (pos == POS_MAX) : (pos == POS_MIN));
  assign fault_set = (step_q & mf_q & ~stop_q) | blocked;

  always_ff @(posedge sysclk) begin
    if (!rst_n) state <= UNHOMED;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch forms.
    state_nxt = state;
    if (stop_q) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        UNHOMED: state_nxt = UNHOMED;
        IDLE:    if (step_ok) state_nxt = MOVING;
        MOVING:  if (!step_ok && idle_cnt == '0) state_nxt = IDLE;
        default: state_nxt = UNHOMED;
      endcase
    end
  end

  always_comb begin
    moving = (state == MOVING);
  end

  // Counter reload is IDLE_CYCLES-1 so MOVING ends exactly IDLE_CYCLES edges
  // after the step that reloaded it.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      pos      <= '0;
      idle_cnt <= '0;
      homed    <= 1'b0;
      fault    <= 1'b0;
    end else begin
      if (stop_q) begin
        pos      <= '0;
        idle_cnt <= '0;
        homed    <= 1'b1;
      end else if (step_ok) begin
        idle_cnt <= CNT_W'(IDLE_CYCLES - 1);
        if (!blocked) pos <= dir_q ? pos + POS_ONE : pos - POS_ONE;
      end else if (idle_cnt != '0) begin
        idle_cnt <= idle_cnt - CNT_W'(1);
      end
      fault <= (fault & ~clr_fault) | fault_set;
    end
  end

endmodule

// File: rtl/pulse_monitor.sv
// Six-axis step-pulse receiver top: per-axis pulse_axis instances plus the
// registered Sel/Pos read port. Optional PU filter: PULSE_MON_FILTER_EN.
module pulse_monitor
  import pulse_pkg::*;
#(
  parameter int NAX         = NAX_DEF,
  parameter int POS_W       = POS_W_DEF,
  parameter int IDLE_CYCLES = 200,
  parameter int FILT_LEN    = 3
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic [NAX-1:0]   PU,
  input  logic [NAX-1:0]   DR,
  input  logic [NAX-1:0]   MF,
  input  logic [NAX-1:0]   Stop,
  input  logic [2:0]       Sel,
  input  logic [NAX-1:0]   ClrFault,
  output logic [POS_W-1:0] Pos,
  output logic [NAX-1:0]   Homed,
  output logic [NAX-1:0]   Moving,
  output logic [NAX-1:0]   Fault
);

  logic [NAX-1:0][POS_W-1:0] pos_all;
  logic [POS_W-1:0]          sel_pos;

  for (genvar i = 0; i < NAX; i++) begin : g_axis
    pulse_axis #(
      .POS_W      (POS_W),
      .IDLE_CYCLES(IDLE_CYCLES),
      .FILT_LEN   (FILT_LEN)
    ) u_axis (
      .sysclk   (sysclk),
      .rst_n    (rst_n),
      .pu       (PU[i]),
      .dr       (DR[i]),
      .mf       (MF[i]),
      .stop     (Stop[i]),
      .clr_fault(ClrFault[i]),
      .pos      (pos_all[i]),
      .homed    (Homed[i]),
      .moving   (Moving[i]),
      .fault    (Fault[i])
    );
  end

  // Selects beyond the last axis fall through to zero.
  always_comb begin
    sel_pos = '0;
    for (int i = 0; i < NAX; i++) begin
      if (Sel == 3'(i)) sel_pos = pos_all[i];
    end
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) Pos <= '0;
    else        Pos <= sel_pos;
  end

endmodule

// File: tb/tb_pulse_monitor.sv
// Directed self-checking bench for pulse_monitor (POS_W=4 so saturation is
// reachable in a few pulses). Filter test follows PULSE_MON_FILTER_EN.
module tb_pulse_monitor;

  localparam int NAX   = 6;
  localparam int POS_W = 4;

  logic             sysclk = 1'b0;
  logic             rst_n  = 1'b0;
  logic [NAX-1:0]   PU = '0, DR = '0, MF = '0, Stop = '0, ClrFault = '0;
  logic [2:0]       Sel = '0;
  logic [POS_W-1:0] Pos;
  logic [NAX-1:0]   Homed, Moving, Fault;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 sysclk = ~sysclk;

  pulse_monitor #(
    .NAX        (NAX),
    .POS_W      (POS_W),
    .IDLE_CYCLES(200),
    .FILT_LEN   (3)
  ) dut (
    .sysclk  (sysclk),
    .rst_n   (rst_n),
    .PU      (PU),
    .DR      (DR),
    .MF      (MF),
    .Stop    (Stop),
    .Sel     (Sel),
    .ClrFault(ClrFault),
    .Pos     (Pos),
    .Homed   (Homed),
    .Moving  (Moving),
    .Fault   (Fault)
  );

  task automatic pulse(input int ax, input int hi, input int lo);
    @(negedge sysclk);
    PU[ax] = 1'b1;
    repeat (hi) @(negedge sysclk);
    PU[ax] = 1'b0;
    repeat (lo) @(negedge sysclk);
  endtask

  task automatic read_pos(input logic [2:0] s, output logic [POS_W-1:0] v);
    @(negedge sysclk);
    Sel = s;
    @(posedge sysclk);
    #1 v = Pos;
  endtask

  task automatic home(input int ax);
    @(negedge sysclk);
    Stop[ax] = 1'b1;
    repeat (10) @(negedge sysclk);
    Stop[ax] = 1'b0;
    repeat (5) @(negedge sysclk);
  endtask

  task automatic test_reset();
    logic [POS_W-1:0] v;
    for (int i = 0; i < 5; i++) begin
      @(negedge sysclk);
      PU = ~PU;
    end
    @(posedge sysclk);
    #1;
    tests_run++;
    if ({Pos, Homed, Moving, Fault} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs got pos=%0d homed=%b moving=%b fault=%b, want all 0",
               Pos, Homed, Moving, Fault);
    end
    @(negedge sysclk);
    PU    = '1;
    rst_n = 1'b1;
    repeat (10) @(negedge sysclk);
    PU = '0;
    repeat (10) @(negedge sysclk);
    read_pos(3'd0, v);
    tests_run++;
    if (v !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_pu_high_release axis0 got %0d want 0", v);
    end
    read_pos(3'd5, v);
    tests_run++;
    if (v !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_pu_high_release axis5 got %0d want 0", v);
    end
  endtask

  task automatic test_homing();
    logic [POS_W-1:0] v;
    @(negedge sysclk);
    Stop[0] = 1'b1;
    repeat (3) @(posedge sysclk);
    #1;
    tests_run++;
    if (Homed !== 6'b000000) begin
      tests_failed++;
      $display("FAIL homing_early got %b want 000000", Homed);
    end
    @(posedge sysclk);
    #1;
    tests_run++;
    if (Homed !== 6'b000001) begin
      tests_failed++;
      $display("FAIL homing_n3 got %b want 000001", Homed);
    end
    repeat (96) @(negedge sysclk);
    Stop[0] = 1'b0;
    read_pos(3'd0, v);
    tests_run++;
    if (v !== 4'd0) begin
      tests_failed++;
      $display("FAIL homing_pos got %0d want 0", v);
    end
  endtask

  task automatic test_counting();
    logic [POS_W-1:0] v;
    home(1);
    DR[1] = 1'b1;
    repeat (5) @(negedge sysclk);
    for (int i = 0; i < 5; i++) pulse(1, 50, 50);
    read_pos(3'd1, v);
    tests_run++;
    if (v !== 4'd5 || Moving[1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL count_up got pos=%0d moving=%b want pos=5 moving=1", v, Moving[1]);
    end
    DR[1] = 1'b0;
    repeat (5) @(negedge sysclk);
    for (int i = 0; i < 2; i++) pulse(1, 50, 50);
    @(negedge sysclk);
    PU[1] = 1'b1;
    @(posedge sysclk);
    for (int k = 1; k <= 202; k++) begin
      @(posedge sysclk);
      if (k == 50) #2 PU[1] = 1'b0;
    end
    #1;
    tests_run++;
    if (Moving[1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL moving_hold got %b want 1", Moving[1]);
    end
    @(posedge sysclk);
    #1;
    tests_run++;
    if (Moving[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL moving_fall got %b want 0", Moving[1]);
    end
    tests_run++;
    if (Pos !== 4'd2) begin
      tests_failed++;
      $display("FAIL count_down got %0d want 2", Pos);
    end
  endtask

  task automatic test_fault();
    logic [POS_W-1:0] v;
    @(negedge sysclk);
    MF[3] = 1'b1;
    repeat (5) @(negedge sysclk);
    for (int i = 0; i < 2; i++) pulse(3, 5, 10);
    read_pos(3'd3, v);
    tests_run++;
    if (v !== 4'd0 || Fault !== 6'b001000) begin
      tests_failed++;
      $display("FAIL fault_set got pos=%0d fault=%b want pos=0 fault=001000", v, Fault);
    end
    @(negedge sysclk);
    ClrFault[3] = 1'b1;
    @(posedge sysclk);
    #1;
    tests_run++;
    if (Fault[3] !== 1'b0) begin
      tests_failed++;
      $display("FAIL fault_clear got %b want 0", Fault[3]);
    end
    @(negedge sysclk);
    ClrFault[3] = 1'b0;
    PU[3] = 1'b1;
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    ClrFault[3] = 1'b1;
    @(posedge sysclk);
    #1;
    tests_run++;
    if (Fault[3] !== 1'b1) begin
      tests_failed++;
      $display("FAIL fault_set_beats_clear got %b want 1", Fault[3]);
    end
    @(negedge sysclk);
    ClrFault[3] = 1'b0;
    PU[3] = 1'b0;
    MF[3] = 1'b0;
    repeat (6) @(negedge sysclk);
    ClrFault[3] = 1'b1;
    @(negedge sysclk);
    ClrFault[3] = 1'b0;
  endtask

  task automatic test_saturation();
    logic [POS_W-1:0] v;
    home(2);
    DR[2] = 1'b1;
    repeat (5) @(negedge sysclk);
    for (int i = 0; i < 9; i++) pulse(2, 2, 6);
    read_pos(3'd2, v);
    tests_run++;
    if (v !== 4'd7 || Fault[2] !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_high got pos=%0d fault=%b want pos=7 fault=1", v, Fault[2]);
    end
    @(negedge sysclk);
    ClrFault[2] = 1'b1;
    DR[2] = 1'b0;
    @(negedge sysclk);
    ClrFault[2] = 1'b0;
    repeat (5) @(negedge sysclk);
    for (int i = 0; i < 16; i++) pulse(2, 2, 6);
    read_pos(3'd2, v);
    tests_run++;
    if (v !== 4'b1000 || Fault[2] !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_low got pos=%b fault=%b want pos=1000 fault=1", v, Fault[2]);
    end
    @(negedge sysclk);
    ClrFault[2] = 1'b1;
    DR[2] = 1'b1;
    @(negedge sysclk);
    ClrFault[2] = 1'b0;
    repeat (5) @(negedge sysclk);
  endtask

  task automatic test_priority();
    logic [POS_W-1:0] v;
    @(negedge sysclk);
    Stop[2] = 1'b1;
    PU[2]   = 1'b1;
    repeat (4) @(negedge sysclk);
    PU[2] = 1'b0;
    repeat (6) @(negedge sysclk);
    read_pos(3'd2, v);
    tests_run++;
    if (v !== 4'd0 || Fault[2] !== 1'b0) begin
      tests_failed++;
      $display("FAIL stop_beats_step got pos=%0d fault=%b want pos=0 fault=0", v, Fault[2]);
    end
    for (int i = 0; i < 2; i++) pulse(2, 3, 6);
    read_pos(3'd2, v);
    tests_run++;
    if (v !== 4'd2) begin
      tests_failed++;
      $display("FAIL stop_held_counts got %0d want 2", v);
    end
    @(negedge sysclk);
    Stop[2] = 1'b0;
    repeat (5) @(negedge sysclk);
    tests_run++;
    if (Homed !== 6'b000111) begin
      tests_failed++;
      $display("FAIL homed_mask got %b want 000111", Homed);
    end
  endtask

  task automatic test_sel();
    logic [POS_W-1:0] v;
    read_pos(3'd6, v);
    tests_run++;
    if (v !== 4'd0) begin
      tests_failed++;
      $display("FAIL sel6 got %0d want 0", v);
    end
    read_pos(3'd7, v);
    tests_run++;
    if (v !== 4'd0) begin
      tests_failed++;
      $display("FAIL sel7 got %0d want 0", v);
    end
    read_pos(3'd1, v);
    tests_run++;
    if (v !== 4'd2) begin
      tests_failed++;
      $display("FAIL sel1_latency got %0d want 2", v);
    end
  endtask

`ifdef PULSE_MON_FILTER_EN
  task automatic test_filter();
    logic [POS_W-1:0] v;
    DR[4] = 1'b1;
    repeat (5) @(negedge sysclk);
    pulse(4, 2, 8);
    read_pos(3'd4, v);
    tests_run++;
    if (v !== 4'd0) begin
      tests_failed++;
      $display("FAIL filter_glitch got %0d want 0", v);
    end
    pulse(4, 3, 8);
    read_pos(3'd4, v);
    tests_run++;
    if (v !== 4'd1) begin
      tests_failed++;
      $display("FAIL filter_pass got %0d want 1", v);
    end
  endtask
`else
  task automatic test_back_to_back();
    logic [POS_W-1:0] v;
    DR[4] = 1'b1;
    repeat (5) @(negedge sysclk);
    pulse(4, 1, 8);
    read_pos(3'd4, v);
    tests_run++;
    if (v !== 4'd1) begin
      tests_failed++;
      $display("FAIL short_pulse got %0d want 1", v);
    end
    pulse(4, 1, 1);
    pulse(4, 1, 8);
    read_pos(3'd4, v);
    tests_run++;
    if (v !== 4'd3) begin
      tests_failed++;
      $display("FAIL back_to_back got %0d want 3", v);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_homing();
    test_counting();
    test_fault();
    test_saturation();
    test_priority();
    test_sel();
`ifdef PULSE_MON_FILTER_EN
    test_filter();
`else
    test_back_to_back();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pulse_monitor.md
# pulse_monitor

Six-axis step-pulse receiver: the consuming end of the `PU`/`MF` stepper interface driven by the `Pulse` generator. It synchronises each axis's step, direction, motor-free and limit (`Stop`) lines, keeps a signed absolute position per axis, and tracks homing, motion and fault status. Motion control reads it back through a registered select/read port for closed-loop checking of issued pulse counts.

## Interface
- `NAX`, 6: number of axes.
- `POS_W`, 16: position width, two's complement.
- `IDLE_CYCLES`, 200: pulse-free cycles after which an axis is no longer moving (2× the nominal 100-cycle pulse period).
- `FILT_LEN`, 3: minimum high cycles for a valid step pulse (used only with the filter macro).

Ports:
- `sysclk` input 1: single clock. All logic is on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `PU` input NAX: step pulses, asynchronous. One rising edge is one step.
- `DR` input NAX: direction, asynchronous. 1 = +1 per step, 0 = −1.
- `MF` input NAX: motor-free, asynchronous. 1 = axis disabled.
- `Stop` input NAX: origin/limit switch, asynchronous, active high.
- `Sel` input 3: axis select for the read port. Values ≥ NAX read as 0.
- `ClrFault` input NAX: per-axis fault clear, single-cycle pulse.
- `Pos` output POS_W: registered position of axis `Sel`.
- `Homed` output NAX: axis has seen a `Stop` since reset.
- `Moving` output NAX: step seen within the last IDLE_CYCLES.
- `Fault` output NAX: sticky fault per axis.

## Operation
- Input sync: 2-flop synchroniser on each of `PU`, `DR`, `MF`, `Stop`. A third register on `PU` and `Stop` provides rising-edge detection.
- Per-axis state machine with states UNHOMED, IDLE, MOVING.
  - Reset → UNHOMED.
  - Any state + `Stop` rising edge → IDLE, position cleared to 0, `Homed` set.
  - IDLE + valid step → MOVING.
  - MOVING + IDLE_CYCLES with no step → IDLE.
  - Steps in UNHOMED are still counted, but `Homed` stays 0.
- Valid step: a `PU` rising edge while synced `MF`=0. Position changes by ±1 per `DR` sampled in the same cycle as the edge.
- Step while `MF`=1: position unchanged, `Fault` set.
- Saturation: position saturates at +2^(POS_W−1)−1 and −2^(POS_W−1). A step that would exceed these limits is dropped and sets `Fault`. Position never wraps.
- `Stop` edge and step edge in the same cycle: `Stop` wins, position = 0, and the step is discarded.
- `Fault` and `ClrFault` in the same cycle: the set wins.
- `Stop` held high: only the rising edge clears position. Steps while `Stop` stays high count normally.
- Idle counter: reloads on every valid step. `Moving` is high only in the MOVING state.

## Timing
- Reset values: all positions 0, `Pos`=0, `Homed`=0, `Moving`=0, `Fault`=0, all states UNHOMED, sync flops 0.
- `rst_n` low mid-pulse clears everything on the next edge. A `PU` line that is high at release does not count as an edge; the edge register resets to 0 and the line must first go low.
- Latency from an input change (sampled at edge n):
  - Position and state update at edge n+3.
  - `Pos` reflects it at edge n+4.
  - `Homed` and `Fault` are visible at n+3.
- `Sel` change → `Pos` valid one cycle later.
- `Moving` falls exactly IDLE_CYCLES cycles after the last step's counter update.

## Configuration
- `PULSE_MON_FILTER_EN` defined: a `PU` high level must persist FILT_LEN consecutive synced cycles before it is accepted as a step. Step latency becomes n+3+FILT_LEN−1. Shorter glitches are ignored silently.
- Macro undefined: no filter. Every synced rising edge is a step.

## Structure
- Shared package `pulse_pkg`: the axis-state enum (UNHOMED/IDLE/MOVING), the NAX default, and the POS_W default. The `Pulse` generator uses the same package for axis count.
- Sub-module `pulse_axis`: one axis containing sync, edge detect, optional filter, state machine, idle counter, saturating position counter and fault. It is instantiated NAX times via generate. The top level holds only the read mux and the `Pos` register.

## Test plan
- Reset: drive `rst_n`=0 for 5 cycles with `PU` toggling. Required: all outputs 0 and no counts after release.
- Homing: `Stop`=6'b00_0001 for 100 cycles. Required: `Homed`=6'b00_0001 at edge n+3, and `Pos` with `Sel`=0 reads 0.
- Counting: axis 1 homed, `DR`=1, 5 pulses at 1000 ns period. Required: `Sel`=1 reads 5 and `Moving[1]`=1. Then `DR`=0 and 3 pulses gives 2. `Moving[1]` falls 200 cycles after the last step.
- Fault: `MF[3]`=1 and 2 pulses on `PU[3]`. Required: position unchanged and `Fault[3]`=1. `ClrFault[3]` pulse clears it. Simultaneous set and clear leaves `Fault[3]`=1.
- Saturation and priority: POS_W=4, 9 up-pulses give 7 with `Fault`=1. A `Stop` edge in the same cycle as a `PU` edge gives 0.
- Filter (macro defined): a 2-cycle `PU` glitch gives no count, and a 3-cycle pulse gives +1.
